// File: rtl/mc_alu.sv
// Multi-cycle ALU: single-cycle logic/arith ops, iterative SLL and MUL, valid/ready on both sides.
// Optional MC_ALU_OVF_EN adds a registered signed-overflow flag for ADD/SUB.
module mc_alu #(
    parameter int WIDTH = 32,
    parameter int SHW   = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       alucontrol,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [SHW-1:0]   shamt,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
`ifdef MC_ALU_OVF_EN
    output logic             ovf,
`endif
    output logic             err
);
    localparam int CW = SHW + 1;
    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SUB = 4'b1010;
    localparam logic [3:0] OP_SLT = 4'b1011;
    localparam logic [3:0] OP_LUI = 4'b1101;
    localparam logic [3:0] OP_SLL = 4'b0100;
    localparam logic [3:0] OP_MUL = 4'b0110;

    typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

    state_t            state, state_nxt;
    logic [3:0]        op;
    logic [CW-1:0]     cnt;
    logic [WIDTH-1:0]  acc, mcand, mplier;
    logic [WIDTH-1:0]  acc_nxt, sll_nxt;
    logic [WIDTH-1:0]  sum, diff, fast_res;
    logic              fast_err, iter_start, last;
`ifdef MC_ALU_OVF_EN
    logic              fast_ovf;
`endif

    assign sum  = a + b;
    assign diff = a - b;
    assign acc_nxt = mplier[0] ? acc + mcand : acc;
    assign sll_nxt = result << 1;
    assign last = (cnt == CW'(1));
    assign iter_start = (alucontrol == OP_MUL) ||
                        ((alucontrol == OP_SLL) && (shamt != '0));

    // SLL with shamt==0 falls through the single-cycle path as a plain copy of b
    always_comb begin
        fast_res = '0;
        fast_err = 1'b0;
`ifdef MC_ALU_OVF_EN
        fast_ovf = 1'b0;
`endif
        unique case (alucontrol)
            OP_AND: fast_res = a & b;
            OP_OR:  fast_res = a | b;
            OP_ADD: begin
                fast_res = sum;
`ifdef MC_ALU_OVF_EN
                fast_ovf = (a[WIDTH-1] == b[WIDTH-1]) &&
                           (sum[WIDTH-1] != a[WIDTH-1]);
`endif
            end
            OP_SUB: begin
                fast_res = diff;
`ifdef MC_ALU_OVF_EN
                fast_ovf = (a[WIDTH-1] != b[WIDTH-1]) &&
                           (diff[WIDTH-1] != a[WIDTH-1]);
`endif
            end
            OP_SLT: fast_res = WIDTH'($signed(a) < $signed(b));
            OP_LUI: fast_res = {{(WIDTH-16){1'b0}}, b[15:0]} << 16;
            OP_SLL: fast_res = b;
            default: fast_err = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: if (in_valid) state_nxt = iter_start ? EXEC : DONE;
            EXEC: if (last) state_nxt = DONE;
            DONE: if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state == IDLE);
        out_valid = (state == DONE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            op     <= '0;
            cnt    <= '0;
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            result <= '0;
            zero   <= 1'b0;
            err    <= 1'b0;
`ifdef MC_ALU_OVF_EN
            ovf    <= 1'b0;
`endif
        end else begin
            unique case (state)
                IDLE: if (in_valid) begin
                    op <= alucontrol;
                    if (alucontrol == OP_MUL) begin
                        cnt    <= CW'(WIDTH);
                        acc    <= '0;
                        mcand  <= a;
                        mplier <= b;
                    end else if (iter_start) begin
                        cnt    <= {1'b0, shamt};
                        result <= b;
                    end else begin
                        result <= fast_res;
                        zero   <= (fast_res == '0);
                        err    <= fast_err;
`ifdef MC_ALU_OVF_EN
                        ovf    <= fast_ovf;
`endif
                    end
                end
                EXEC: begin
                    cnt <= cnt - CW'(1);
                    if (op == OP_MUL) begin
                        acc    <= acc_nxt;
                        mcand  <= mcand << 1;
                        mplier <= mplier >> 1;
                        if (last) begin
                            result <= acc_nxt;
                            zero   <= (acc_nxt == '0);
                        end
                    end else begin
                        result <= sll_nxt;
                        if (last) zero <= (sll_nxt == '0);
                    end
                    if (last) begin
                        err <= 1'b0;
`ifdef MC_ALU_OVF_EN
                        ovf <= 1'b0;
`endif
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: doc/mc_alu.md
Name: mc_alu

Overview:
- Multi-cycle ALU and the consumer of the 4-bit alucontrol encoding produced by the ALU decoder.
- Operands and an alucontrol code are accepted over a valid/ready handshake. Simple ops complete in one cycle; shift and multiply iterate. A registered result is presented over a second valid/ready handshake.
- Sits in the execute stage of the multi-cycle datapath, between the register/immediate operand muxes and the result writeback.

Parameters:
- WIDTH, 32, operand/result width in bits (must be >= 17).
- SHW, 5, shamt width; must satisfy 2**SHW == WIDTH.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- in_valid  input  1  request valid.
- in_ready  output  1  block can accept a request.
- alucontrol  input  4  operation code (see Behaviour).
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- shamt  input  SHW  shift amount for SLL.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer takes result.
- result  output  WIDTH  registered result.
- zero  output  1  result == 0.
- err  output  1  unsupported alucontrol code.

Behaviour:
- Op codes:
  - 0000 AND (a&b); 0001 OR (a|b); 0010 ADD (a+b, mod 2^WIDTH); 1010 SUB (a-b, mod 2^WIDTH).
  - 1011 SLT: signed a<b, yields 1 or 0.
  - 1101 LUI: b[15:0] << 16; upper bits of b ignored.
  - 0100 SLL: b << shamt, iterative, one bit per cycle.
  - 0110 MUL: low WIDTH bits of a*b, iterative shift-add, one multiplier bit per cycle.
  - Any other code: result=0, err=1, single-cycle.
- FSM states IDLE, EXEC, DONE. in_ready = (state==IDLE). out_valid = (state==DONE).
- IDLE: when in_valid at edge T, latch operands and code.
  - Single-cycle op, or SLL with shamt==0: result written at edge T, go DONE. out_valid is high in the cycle after acceptance.
  - SLL with shamt>0: go EXEC with counter=shamt.
  - MUL: go EXEC with counter=WIDTH, accumulator=0.
- EXEC, SLL: each cycle result<=result<<1 and counter decrements. Go DONE on the edge where counter reaches 0. Total acceptance-to-out_valid = shamt+1 cycles.
- EXEC, MUL: each cycle, if mplier[0] then acc+=mcand. Then mcand<<=1, mplier>>=1, counter decrements. Go DONE after WIDTH iterations. Latency = WIDTH+1 cycles. No early exit.
- DONE: result, zero and err are held stable while out_valid && !out_ready. On out_ready go IDLE.
  - No new request is accepted in the DONE cycle. Minimum initiation interval is 2 cycles.
- zero and err are registered together with the final result and change only on entry to DONE.
- Changes on a, b, alucontrol or shamt after acceptance have no effect on the operation in flight.
- Reset (any state, including mid-EXEC): state=IDLE, result=0, zero=0, err=0, counter=0. in_ready=1 and out_valid=0 while reset is asserted. An in-flight operation is discarded with no output.
- in_valid is ignored outside IDLE. out_ready is ignored outside DONE.

Optional Feature:
- Macro: MC_ALU_OVF_EN.
- Defined:
  - Adds output port ovf (1 bit), registered with the result.
  - ADD: ovf=1 when a and b have the same sign and the result sign differs.
  - SUB: ovf=1 when a and b have different signs and the result sign differs from a.
  - All other ops: ovf=0. Reset value 0.
- Undefined: no ovf port, no overflow logic. All other behaviour is identical.

Test Plan:
- Reset release, then ADD a=0x7FFFFFFF b=1 -> out_valid 1 cycle after accept, result=0x80000000, zero=0, err=0, ovf=1 (MC_ALU_OVF_EN).
- SUB a=5 b=5 -> result=0, zero=1. SLT a=0xFFFFFFFF b=1 -> result=1. LUI b=0xABCD1234 -> result=0x12340000.
- SLL b=0x1 shamt=31 -> out_valid 32 cycles after accept, result=0x80000000. SLL shamt=0, b=0xF -> 1-cycle latency, result=0xF.
- MUL a=0xFFFFFFFF b=3 -> latency 33 cycles, result=0xFFFFFFFD. Hold out_ready=0 for 5 cycles -> result stable, in_ready=0, new in_valid ignored.
- Code 0111 -> result=0, err=1, 1-cycle latency. Next request with code 0001 a=0xF0 b=0x0F -> err=0, result=0xFF.
- MUL accepted, reset asserted after 10 EXEC cycles -> outputs immediately return to reset values, out_valid never rises. After release, ADD 2+3 -> result=5.
